// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline: carries decoded controls ID->EX->MEM->WB, detects load-use
// hazards, resolves taken branches and drives forwarding selects. Macro: CTRL_PIPE_FWD_EN.
module ctrl_pipe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic       id_reg_dst,
   input  logic       id_alu_src,
   input  logic       id_mem_to_reg,
   input  logic       id_reg_write,
   input  logic       id_mem_read,
   input  logic       id_mem_write,
   input  logic       id_branch,
   input  logic [1:0] id_alu_op,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic [4:0] id_rd,
   input  logic       ex_zero,
   output logic       ex_valid,
   output logic       ex_reg_dst,
   output logic       ex_alu_src,
   output logic       ex_mem_to_reg,
   output logic       ex_reg_write,
   output logic       ex_mem_read,
   output logic       ex_mem_write,
   output logic       ex_branch,
   output logic [1:0] ex_alu_op,
   output logic [4:0] ex_rs,
   output logic [4:0] ex_rt,
   output logic [4:0] ex_dest,
   output logic       mem_valid,
   output logic       mem_mem_read,
   output logic       mem_mem_write,
   output logic       mem_mem_to_reg,
   output logic       mem_reg_write,
   output logic [4:0] mem_dest,
   output logic       wb_valid,
   output logic       wb_mem_to_reg,
   output logic       wb_reg_write,
   output logic [4:0] wb_dest,
   output logic       stall,
   output logic       flush,
   output logic       branch_taken,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   typedef struct packed {
      logic       valid;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dest;
   } ex_bundle_t;

   typedef struct packed {
      logic       valid;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic [4:0] dest;
   } mem_bundle_t;

   typedef struct packed {
      logic       valid;
      logic       mem_to_reg;
      logic       reg_write;
      logic [4:0] dest;
   } wb_bundle_t;

   ex_bundle_t  ex_q, id_bundle;
   mem_bundle_t mem_q;
   wb_bundle_t  wb_q;
   logic [4:0]  id_dest;
   logic        stall_raw;

   // A $0 operand never matches a producer, whatever the producer's dest holds.
   function automatic logic reg_hit(input logic [4:0] dest, input logic [4:0] src);
      return (src != 5'd0) && (dest == src);
   endfunction

   assign branch_taken = ex_q.valid & ex_q.branch & ex_zero;
   assign flush        = branch_taken;
   assign stall        = stall_raw & ~branch_taken;
   assign id_dest      = id_reg_dst ? id_rd : id_rt;

`ifdef CTRL_PIPE_FWD_EN
   logic ex_load;
   assign ex_load   = ex_q.valid & ex_q.mem_read & ~ex_q.reg_dst;
   assign stall_raw = ex_load & id_valid &
                      (reg_hit(ex_q.dest, id_rs) | reg_hit(ex_q.dest, id_rt));

   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      if (mem_q.valid && mem_q.reg_write && reg_hit(mem_q.dest, src))
         return 2'b10;
      else if (wb_q.valid && wb_q.reg_write && reg_hit(wb_q.dest, src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign fwd_a = fwd_sel(ex_q.rs);
   assign fwd_b = fwd_sel(ex_q.rt);
`else
   // Without bypassing, wait until producers in EX and MEM have reached WB.
   assign stall_raw = id_valid & (
      (ex_q.valid & ex_q.reg_write &
       (reg_hit(ex_q.dest, id_rs) | reg_hit(ex_q.dest, id_rt))) |
      (mem_q.valid & mem_q.reg_write &
       (reg_hit(mem_q.dest, id_rs) | reg_hit(mem_q.dest, id_rt))));
   assign fwd_a = 2'b00;
   assign fwd_b = 2'b00;
`endif

   always_comb begin
      id_bundle = '0;
      if (id_valid && !stall && !branch_taken) begin
         id_bundle.valid      = 1'b1;
         id_bundle.reg_dst    = id_reg_dst;
         id_bundle.alu_src    = id_alu_src;
         id_bundle.mem_to_reg = id_mem_to_reg;
         id_bundle.reg_write  = id_reg_write & (id_dest != 5'd0);
         id_bundle.mem_read   = id_mem_read;
         id_bundle.mem_write  = id_mem_write;
         id_bundle.branch     = id_branch;
         id_bundle.alu_op     = id_alu_op;
         id_bundle.rs         = id_rs;
         id_bundle.rt         = id_rt;
         id_bundle.dest       = id_dest;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= id_bundle;
         mem_q <= '{valid: ex_q.valid, mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                    mem_to_reg: ex_q.mem_to_reg, reg_write: ex_q.reg_write, dest: ex_q.dest};
         wb_q  <= '{valid: mem_q.valid, mem_to_reg: mem_q.mem_to_reg,
                    reg_write: mem_q.reg_write, dest: mem_q.dest};
      end
   end

   assign ex_valid       = ex_q.valid;
   assign ex_reg_dst     = ex_q.reg_dst;
   assign ex_alu_src     = ex_q.alu_src;
   assign ex_mem_to_reg  = ex_q.mem_to_reg;
   assign ex_reg_write   = ex_q.reg_write;
   assign ex_mem_read    = ex_q.mem_read;
   assign ex_mem_write   = ex_q.mem_write;
   assign ex_branch      = ex_q.branch;
   assign ex_alu_op      = ex_q.alu_op;
   assign ex_rs          = ex_q.rs;
   assign ex_rt          = ex_q.rt;
   assign ex_dest        = ex_q.dest;
   assign mem_valid      = mem_q.valid;
   assign mem_mem_read   = mem_q.mem_read;
   assign mem_mem_write  = mem_q.mem_write;
   assign mem_mem_to_reg = mem_q.mem_to_reg;
   assign mem_reg_write  = mem_q.reg_write;
   assign mem_dest       = mem_q.dest;
   assign wb_valid       = wb_q.valid;
   assign wb_mem_to_reg  = wb_q.mem_to_reg;
   assign wb_reg_write   = wb_q.reg_write;
   assign wb_dest        = wb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: per-edge EX expectations are queued and later
// compared against the MEM and WB stages; hazard/forward outputs checked per step.
module tb_ctrl_pipe;

`ifdef CTRL_PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // ctl word: {reg_dst, alu_src, mem_read, mem_write, branch, alu_op}
   localparam logic [6:0] R_CTL   = 7'b1000010;
   localparam logic [6:0] LW_CTL  = 7'b0110000;
   localparam logic [6:0] BEQ_CTL = 7'b0000101;

   logic       clk, rst_n;
   logic       id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
   logic       id_mem_read, id_mem_write, id_branch;
   logic [1:0] id_alu_op;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       ex_zero;
   logic       ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
   logic       ex_mem_read, ex_mem_write, ex_branch;
   logic [1:0] ex_alu_op;
   logic [4:0] ex_rs, ex_rt, ex_dest;
   logic       mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
   logic [4:0] mem_dest;
   logic       wb_valid, wb_mem_to_reg, wb_reg_write;
   logic [4:0] wb_dest;
   logic       stall, flush, branch_taken;
   logic [1:0] fwd_a, fwd_b;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   ctrl_pipe dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_dst(id_reg_dst),
      .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
      .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
      .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .mem_valid(mem_valid),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
      .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
      .wb_dest(wb_dest), .stall(stall), .flush(flush), .branch_taken(branch_taken),
      .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] wd(input logic v, input logic m2r, input logic rw,
                                     input logic [4:0] dest);
      return {v, m2r, rw, dest};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic set_id(input logic v, input logic [6:0] ctl, input logic m2r,
                         input logic rw, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
      id_valid = v;
      {id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_branch, id_alu_op} = ctl;
      id_mem_to_reg = m2r;
      id_reg_write  = rw;
      id_rs = rs;
      id_rt = rt;
      id_rd = rd;
   endtask

   task automatic comb(input string tag, input logic [2:0] exp_sfb,
                       input logic [1:0] exp_fa, input logic [1:0] exp_fb);
      #1;
      chk({tag, "/hazard"}, {stall, flush, branch_taken}, exp_sfb);
      chk({tag, "/fwd"}, {fwd_a, fwd_b}, {exp_fa, exp_fb});
   endtask

   // scoreboard: the EX word captured now is expected on MEM next edge and WB after
   task automatic tick(input string tag, input logic [7:0] exp_ex, input logic [6:0] exp_ctl,
                       input logic [4:0] exp_rs, input logic [4:0] exp_rt);
      logic [7:0] exp_wb;
      @(posedge clk);
      #1;
      exp_q.push_back(exp_ex);
      exp_wb = exp_q.pop_front();
      chk({tag, "/ex"}, {ex_valid, ex_mem_to_reg, ex_reg_write, ex_dest}, exp_ex);
      chk({tag, "/ex_ctl"},
          {ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_branch, ex_alu_op}, exp_ctl);
      chk({tag, "/ex_src"}, {ex_rs, ex_rt}, {exp_rs, exp_rt});
      chk({tag, "/mem"}, {mem_valid, mem_mem_to_reg, mem_reg_write, mem_dest}, exp_q[0]);
      chk({tag, "/wb"}, {wb_valid, wb_mem_to_reg, wb_reg_write, wb_dest}, exp_wb);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "/ex"}, {ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
                         ex_mem_read, ex_mem_write, ex_branch, ex_alu_op}, 16'd0);
      chk({tag, "/ex_spec"}, {1'b0, ex_rs, ex_rt, ex_dest}, 16'd0);
      chk({tag, "/mem"}, {mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg,
                          mem_reg_write, mem_dest}, 16'd0);
      chk({tag, "/wb"}, {wb_valid, wb_mem_to_reg, wb_reg_write, wb_dest}, 16'd0);
      chk({tag, "/hazard"}, {stall, flush, branch_taken, fwd_a, fwd_b}, 16'd0);
   endtask

   task automatic nop_tick(input string tag);
      set_id(1'b0, 7'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick(tag, 8'd0, 7'd0, 5'd0, 5'd0);
   endtask

   initial begin
      // reset held with a live ID bundle
      rst_n   = 1'b0;
      ex_zero = 1'b0;
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd0);
      rst_n = 1'b1;

      // add r3, then independent add r4, then a masked invalid slot
      comb("s1", 3'b000, 2'b00, 2'b00);
      tick("s1", wd(1, 0, 1, 5'd3), R_CTL, 5'd1, 5'd2);
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd5, 5'd6, 5'd4);
      comb("s2", 3'b000, 2'b00, 2'b00);
      tick("s2", wd(1, 0, 1, 5'd4), R_CTL, 5'd5, 5'd6);
      set_id(1'b0, R_CTL, 1'b0, 1'b1, 5'd5, 5'd6, 5'd4);
      comb("s3", 3'b000, 2'b00, 2'b00);
      tick("s3", 8'd0, 7'd0, 5'd0, 5'd0);

      // lw r5 then add r6 = r5 + r2
      set_id(1'b1, LW_CTL, 1'b1, 1'b1, 5'd1, 5'd5, 5'd9);
      comb("s4", 3'b000, 2'b00, 2'b00);
      tick("s4", wd(1, 1, 1, 5'd5), LW_CTL, 5'd1, 5'd5);
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd5, 5'd2, 5'd6);
      comb("s5_ld_use", 3'b100, 2'b00, 2'b00);
      tick("s5", 8'd0, 7'd0, 5'd0, 5'd0);
`ifndef CTRL_PIPE_FWD_EN
      comb("s6_stall2", 3'b100, 2'b00, 2'b00);
      tick("s6b", 8'd0, 7'd0, 5'd0, 5'd0);
`endif
      comb("s6", 3'b000, 2'b00, 2'b00);
      tick("s6", wd(1, 0, 1, 5'd6), R_CTL, 5'd5, 5'd2);
      set_id(1'b0, 7'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      comb("s7_fwd_ld", 3'b000, FWD ? 2'b01 : 2'b00, 2'b00);
      tick("s7", 8'd0, 7'd0, 5'd0, 5'd0);

      // add r7; beq r1,r2; consumer of r7 while the branch resolves taken
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd1, 5'd2, 5'd7);
      comb("t1", 3'b000, 2'b00, 2'b00);
      tick("t1", wd(1, 0, 1, 5'd7), R_CTL, 5'd1, 5'd2);
      set_id(1'b1, BEQ_CTL, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
      comb("t2", 3'b000, 2'b00, 2'b00);
      tick("t2", wd(1, 0, 0, 5'd2), BEQ_CTL, 5'd1, 5'd2);
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd7, 5'd1, 5'd8);
      comb("t3_not_taken", {FWD ? 1'b0 : 1'b1, 2'b00}, 2'b00, 2'b00);
      ex_zero = 1'b1;
      comb("t3_taken", 3'b011, 2'b00, 2'b00);
      tick("t3", 8'd0, 7'd0, 5'd0, 5'd0);
      ex_zero = 1'b0;
      nop_tick("t4");

      // write to $0 is suppressed
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0);
      comb("u1", 3'b000, 2'b00, 2'b00);
      tick("u1_rd0", wd(1, 0, 0, 5'd0), R_CTL, 5'd1, 5'd2);
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9);
      comb("u2", 3'b000, 2'b00, 2'b00);
      tick("u2", wd(1, 0, 1, 5'd9), R_CTL, 5'd0, 5'd0);
      set_id(1'b0, 7'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      comb("u3_r0_nofwd", 3'b000, 2'b00, 2'b00);
      tick("u3", 8'd0, 7'd0, 5'd0, 5'd0);

      // back-to-back writes to r7, then consumers of r7
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd1, 5'd2, 5'd7);
      comb("v1", 3'b000, 2'b00, 2'b00);
      tick("v1", wd(1, 0, 1, 5'd7), R_CTL, 5'd1, 5'd2);
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd3, 5'd4, 5'd7);
      comb("v2", 3'b000, 2'b00, 2'b00);
      tick("v2", wd(1, 0, 1, 5'd7), R_CTL, 5'd3, 5'd4);
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd7, 5'd11, 5'd10);
`ifndef CTRL_PIPE_FWD_EN
      comb("v3_stall_ex", 3'b100, 2'b00, 2'b00);
      tick("v3a", 8'd0, 7'd0, 5'd0, 5'd0);
      comb("v3_stall_mem", 3'b100, 2'b00, 2'b00);
      tick("v3b", 8'd0, 7'd0, 5'd0, 5'd0);
`endif
      comb("v3", 3'b000, 2'b00, 2'b00);
      tick("v3", wd(1, 0, 1, 5'd10), R_CTL, 5'd7, 5'd11);
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd1, 5'd7, 5'd12);
      comb("v4_fwd_newer", 3'b000, FWD ? 2'b10 : 2'b00, 2'b00);
      tick("v4", wd(1, 0, 1, 5'd12), R_CTL, 5'd1, 5'd7);
      set_id(1'b0, 7'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      comb("v5_fwd_wb", 3'b000, 2'b00, FWD ? 2'b01 : 2'b00);
      tick("v5", 8'd0, 7'd0, 5'd0, 5'd0);

      // mid-stream reset drops everything at once
      set_id(1'b1, R_CTL, 1'b0, 1'b1, 5'd1, 5'd2, 5'd13);
      tick("w1", wd(1, 0, 1, 5'd13), R_CTL, 5'd1, 5'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midreset");
      exp_q.delete();
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd0);
      tick("w2_inreset", 8'd0, 7'd0, 5'd0, 5'd0);
      rst_n = 1'b1;
      set_id(1'b1, LW_CTL, 1'b1, 1'b1, 5'd2, 5'd3, 5'd0);
      comb("w3", 3'b000, 2'b00, 2'b00);
      tick("w3", wd(1, 1, 1, 5'd3), LW_CTL, 5'd2, 5'd3);
      nop_tick("w4");
      nop_tick("w5");
      nop_tick("w6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
